// File: rtl/press_counter_pkg.sv
// Shared types and constants for the press_counter block.
//   state_e    : press-classification FSM states
//   MODE_CLEAR : LONG_MODE value, a long press clears the count
//   MODE_DEC   : LONG_MODE value, a long press decrements the count
package press_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TIMING,
      ST_LONG_HELD
   } state_e;

   localparam int MODE_CLEAR = 0;
   localparam int MODE_DEC   = 1;

endpackage

// File: rtl/press_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer for an
// active-low pushbutton.
//   clk          : system clock
//   reset        : asynchronous active-high reset, forces the open level
//   button       : raw pushbutton, 1 = open, 0 = pressed
//   pressed      : debounced pressed level (1 = pressed)
//   press_edge   : one-cycle pulse when the debounced level becomes pressed
//   release_edge : one-cycle pulse when the debounced level becomes open
module press_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic pressed,
   output logic press_edge,
   output logic release_edge
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_edge_q, press_edge_d;
   logic             release_edge_q, release_edge_d;

   // The counter tracks consecutive cycles where the synchronised input
   // disagrees with the accepted level; any agreeing cycle clears it.
   always_comb begin
      cnt_d          = '0;
      deb_d          = deb_q;
      press_edge_d   = 1'b0;
      release_edge_d = 1'b0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            deb_d          = sync2_q;
            press_edge_d   = ~sync2_q;
            release_edge_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q        <= 1'b1;
         sync2_q        <= 1'b1;
         deb_q          <= 1'b1;
         cnt_q          <= '0;
         press_edge_q   <= 1'b0;
         release_edge_q <= 1'b0;
      end else begin
         sync1_q        <= button;
         sync2_q        <= sync1_q;
         deb_q          <= deb_d;
         cnt_q          <= cnt_d;
         press_edge_q   <= press_edge_d;
         release_edge_q <= release_edge_d;
      end
   end

   assign pressed      = ~deb_q;
   assign press_edge   = press_edge_q;
   assign release_edge = release_edge_q;

endmodule

// File: rtl/press_counter.sv
// Pushbutton press counter: debounces the button, classifies each press
// as short, void (dead zone) or long by its duration, and updates a
// wrapping counter from short and long presses.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   button      : raw pushbutton, 1 = open, 0 = pressed
//   en          : 1 = presses modify count, 0 = count frozen
//   count       : current count value
//   held        : debounced pressed level, one register of latency
//   press_short : one-cycle pulse on a short press
//   press_long  : one-cycle pulse when a press becomes long (while held)
//   press_void  : one-cycle pulse on release of a dead-zone press
//   wrap        : one-cycle pulse when count wraps in either direction
module press_counter
   import press_counter_pkg::*;
#(
   parameter int WIDTH      = 3,
   parameter int MAX_COUNT  = 7,
   parameter int DEB_CYCLES = 16,
   parameter int SHORT_MAX  = 2000,
   parameter int LONG_MIN   = 4000,
   parameter int LONG_MODE  = MODE_CLEAR,
   parameter int TIMER_W    = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             button,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             held,
   output logic             press_short,
   output logic             press_long,
   output logic             press_void,
   output logic             wrap
);

   logic deb_pressed, deb_press, deb_release;

   press_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .button      (button),
      .pressed     (deb_pressed),
      .press_edge  (deb_press),
      .release_edge(deb_release)
   );

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic                 held_q, held_d;
   logic                 short_q, short_d;
   logic                 long_q, long_d;
   logic                 void_q, void_d;
   logic                 wrap_q, wrap_d;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      void_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (deb_press) begin
               state_d = ST_TIMING;
               timer_d = TIMER_W'(1);
            end
         end
         ST_TIMING: begin
            // Release is resolved before the long threshold so a press
            // never produces two classifications.
            if (deb_release) begin
               state_d = ST_IDLE;
               timer_d = '0;
               if (timer_q < TIMER_W'(SHORT_MAX)) short_d = 1'b1;
               else                               void_d  = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
               if (timer_d == TIMER_W'(LONG_MIN)) begin
                  state_d = ST_LONG_HELD;
                  long_d  = 1'b1;
               end
            end
         end
         ST_LONG_HELD: begin
            timer_d = TIMER_W'(LONG_MIN);
            if (deb_release) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      held_d  = deb_pressed;
      if (en) begin
         if (short_d) begin
            if (count_q == WIDTH'(MAX_COUNT)) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else if (long_d) begin
            if (LONG_MODE == MODE_DEC) begin
               if (count_q == '0) begin
                  count_d = WIDTH'(MAX_COUNT);
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end else begin
               count_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         count_q <= '0;
         held_q  <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         void_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         count_q <= count_d;
         held_q  <= held_d;
         short_q <= short_d;
         long_q  <= long_d;
         void_q  <= void_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count       = count_q;
   assign held        = held_q;
   assign press_short = short_q;
   assign press_long  = long_q;
   assign press_void  = void_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter. Two instances share the stimulus:
// index 0 uses LONG_MODE=0 (clear), index 1 uses LONG_MODE=1 (decrement).
module tb_press_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       button = 1'b1;
   logic       en = 1'b1;
   logic [2:0] cnt [2];
   logic [1:0] hd, ps, pl, pv, wr;

   int n_checks = 0;
   int n_fail   = 0;

   // cumulative event totals gathered on the falling edge
   int ts[2], tl[2], tv[2], tw[2], th[2];
   int bs[2], bl[2], bv[2], bw[2], bh[2];
   int onehot_bad = 0, long_unheld = 0;
   int b_onehot, b_unheld;

   always #5 clk = ~clk;

   press_counter #(.WIDTH(3), .MAX_COUNT(7), .DEB_CYCLES(4), .SHORT_MAX(20),
                   .LONG_MIN(40), .LONG_MODE(0), .TIMER_W(17)) dut0 (
      .clk(clk), .reset(reset), .button(button), .en(en), .count(cnt[0]),
      .held(hd[0]), .press_short(ps[0]), .press_long(pl[0]),
      .press_void(pv[0]), .wrap(wr[0]));

   press_counter #(.WIDTH(3), .MAX_COUNT(7), .DEB_CYCLES(4), .SHORT_MAX(20),
                   .LONG_MIN(40), .LONG_MODE(1), .TIMER_W(17)) dut1 (
      .clk(clk), .reset(reset), .button(button), .en(en), .count(cnt[1]),
      .held(hd[1]), .press_short(ps[1]), .press_long(pl[1]),
      .press_void(pv[1]), .wrap(wr[1]));

   initial begin
      for (int i = 0; i < 2; i++) begin
         ts[i] = 0; tl[i] = 0; tv[i] = 0; tw[i] = 0; th[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ps[i]) ts[i]++;
         if (pl[i]) tl[i]++;
         if (pv[i]) tv[i]++;
         if (wr[i]) tw[i]++;
         if (hd[i]) th[i]++;
         if ($countones({ps[i], pl[i], pv[i]}) > 1) onehot_bad++;
         if (pl[i] && !hd[i]) long_unheld++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      bs = ts; bl = tl; bv = tv; bw = tw; bh = th;
      b_onehot = onehot_bad; b_unheld = long_unheld;
   endtask

   task automatic press(input int n);
      button = 1'b0;
      cyc(n);
      button = 1'b1;
      cyc(20);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(2);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (cnt[i] !== 3'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt[i]); end
         n_checks++;
         if ({hd[i], ps[i], pl[i], pv[i], wr[i]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs[%0d]: got %b want 00000", i, {hd[i], ps[i], pl[i], pv[i], wr[i]});
         end
      end
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_short();
      apply_reset();
      snap();
      press(10);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (ts[i] - bs[i] !== 1) begin n_fail++; $display("FAIL short_pulses[%0d]: got %0d want 1", i, ts[i] - bs[i]); end
         n_checks++;
         if ((tl[i] - bl[i]) + (tv[i] - bv[i]) !== 0) begin n_fail++; $display("FAIL short_other[%0d]: got %0d want 0", i, (tl[i] - bl[i]) + (tv[i] - bv[i])); end
         n_checks++;
         if (cnt[i] !== 3'd1) begin n_fail++; $display("FAIL short_count[%0d]: got %0d want 1", i, cnt[i]); end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      snap();
      for (int k = 0; k < 8; k++) begin
         press(10);
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cnt[i] !== 3'((k + 1) % 8)) begin
               n_fail++; $display("FAIL wrap_step%0d[%0d]: got %0d want %0d", k, i, cnt[i], (k + 1) % 8);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (tw[i] - bw[i] !== 1) begin n_fail++; $display("FAIL wrap_pulses[%0d]: got %0d want 1", i, tw[i] - bw[i]); end
      end
   endtask

   task automatic test_long_clear();
      apply_reset();
      repeat (5) press(10);
      snap();
      press(60);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (tl[i] - bl[i] !== 1) begin n_fail++; $display("FAIL long_pulses[%0d]: got %0d want 1", i, tl[i] - bl[i]); end
         n_checks++;
         if ((ts[i] - bs[i]) + (tv[i] - bv[i]) !== 0) begin n_fail++; $display("FAIL long_release_pulse[%0d]: got %0d want 0", i, (ts[i] - bs[i]) + (tv[i] - bv[i])); end
         n_checks++;
         if (tw[i] - bw[i] !== 0) begin n_fail++; $display("FAIL long_wrap[%0d]: got %0d want 0", i, tw[i] - bw[i]); end
      end
      n_checks++;
      if (long_unheld - b_unheld !== 0) begin n_fail++; $display("FAIL long_while_held: got %0d unheld pulses want 0", long_unheld - b_unheld); end
      n_checks++;
      if (cnt[0] !== 3'd0) begin n_fail++; $display("FAIL long_clear_count: got %0d want 0", cnt[0]); end
      n_checks++;
      if (cnt[1] !== 3'd4) begin n_fail++; $display("FAIL long_dec_count: got %0d want 4", cnt[1]); end
   endtask

   task automatic test_long_dec_void();
      apply_reset();
      snap();
      press(50);
      n_checks++;
      if (cnt[1] !== 3'd7) begin n_fail++; $display("FAIL dec_wrap_count: got %0d want 7", cnt[1]); end
      n_checks++;
      if (tw[1] - bw[1] !== 1) begin n_fail++; $display("FAIL dec_wrap_pulse: got %0d want 1", tw[1] - bw[1]); end
      n_checks++;
      if (cnt[0] !== 3'd0 || tw[0] - bw[0] !== 0) begin n_fail++; $display("FAIL clear_from_zero: got count %0d wraps %0d want 0 0", cnt[0], tw[0] - bw[0]); end
      snap();
      press(30);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (tv[i] - bv[i] !== 1) begin n_fail++; $display("FAIL void_pulses[%0d]: got %0d want 1", i, tv[i] - bv[i]); end
         n_checks++;
         if ((ts[i] - bs[i]) + (tl[i] - bl[i]) !== 0) begin n_fail++; $display("FAIL void_other[%0d]: got %0d want 0", i, (ts[i] - bs[i]) + (tl[i] - bl[i])); end
      end
      n_checks++;
      if (cnt[0] !== 3'd0 || cnt[1] !== 3'd7) begin n_fail++; $display("FAIL void_counts: got %0d/%0d want 0/7", cnt[0], cnt[1]); end
   endtask

   task automatic test_bounce();
      snap();
      repeat (3) begin
         button = 1'b0; cyc(3);
         button = 1'b1; cyc(3);
      end
      cyc(20);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ((ts[i] - bs[i]) + (tl[i] - bl[i]) + (tv[i] - bv[i]) !== 0) begin
            n_fail++; $display("FAIL bounce_events[%0d]: got %0d want 0", i, (ts[i] - bs[i]) + (tl[i] - bl[i]) + (tv[i] - bv[i]));
         end
         n_checks++;
         if (th[i] - bh[i] !== 0) begin n_fail++; $display("FAIL bounce_held[%0d]: got %0d held cycles want 0", i, th[i] - bh[i]); end
      end
      n_checks++;
      if (cnt[0] !== 3'd0 || cnt[1] !== 3'd7) begin n_fail++; $display("FAIL bounce_counts: got %0d/%0d want 0/7", cnt[0], cnt[1]); end
   endtask

   task automatic test_en_off();
      en = 1'b0;
      snap();
      press(10);
      en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (ts[i] - bs[i] !== 1) begin n_fail++; $display("FAIL en_off_pulse[%0d]: got %0d want 1", i, ts[i] - bs[i]); end
         n_checks++;
         if (tw[i] - bw[i] !== 0) begin n_fail++; $display("FAIL en_off_wrap[%0d]: got %0d want 0", i, tw[i] - bw[i]); end
      end
      n_checks++;
      if (cnt[0] !== 3'd0 || cnt[1] !== 3'd7) begin n_fail++; $display("FAIL en_off_counts: got %0d/%0d want 0/7", cnt[0], cnt[1]); end
   endtask

   task automatic test_reset_mid();
      press(10);
      press(10);
      n_checks++;
      if (cnt[0] !== 3'd2 || cnt[1] !== 3'd1) begin n_fail++; $display("FAIL pre_reset_counts: got %0d/%0d want 2/1", cnt[0], cnt[1]); end
      snap();
      button = 1'b0;
      cyc(15);
      reset = 1'b1;
      #1;
      n_checks++;
      if (cnt[0] !== 3'd0 || cnt[1] !== 3'd0 || hd !== 2'b00) begin
         n_fail++; $display("FAIL async_reset: got counts %0d/%0d held %b want 0/0 00", cnt[0], cnt[1], hd);
      end
      cyc(1);
      reset = 1'b0;
      cyc(2);
      button = 1'b1;
      cyc(30);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ((ts[i] - bs[i]) + (tl[i] - bl[i]) + (tv[i] - bv[i]) !== 0) begin
            n_fail++; $display("FAIL reset_mid_events[%0d]: got %0d want 0", i, (ts[i] - bs[i]) + (tl[i] - bl[i]) + (tv[i] - bv[i]));
         end
         n_checks++;
         if (cnt[i] !== 3'd0) begin n_fail++; $display("FAIL reset_mid_count[%0d]: got %0d want 0", i, cnt[i]); end
      end
   endtask

   task automatic test_reset_renew();
      snap();
      button = 1'b0;
      cyc(5);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(12);
      button = 1'b1;
      cyc(20);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (ts[i] - bs[i] !== 1) begin n_fail++; $display("FAIL renew_pulse[%0d]: got %0d want 1", i, ts[i] - bs[i]); end
         n_checks++;
         if (cnt[i] !== 3'd1) begin n_fail++; $display("FAIL renew_count[%0d]: got %0d want 1", i, cnt[i]); end
      end
      n_checks++;
      if (onehot_bad !== 0) begin n_fail++; $display("FAIL onehot_pulses: got %0d overlapping cycles want 0", onehot_bad); end
   endtask

   initial begin
      test_reset();
      test_short();
      test_wrap();
      test_long_clear();
      test_long_dec_void();
      test_bounce();
      test_en_off();
      test_reset_mid();
      test_reset_renew();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
